// File: rtl/ccr_unit.sv
// Condition-code register stage behind the EX-stage ALU.
// Holds {N,C,Z}, resolves JZ/JN/JC and keeps a small LIFO of flag sets for interrupt nesting.
module ccr_unit #(
  parameter int FLAG_W     = 3,
  parameter int SAVE_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] flag_we,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        jmp_cond,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] ccr,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  save_count,
  output logic              err
);

  localparam int ZERO_B  = 0;
  localparam int CARRY_B = 1;
  localparam int NEG_B   = 2;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_Z    = 2'b01,
    JMP_N    = 2'b10,
    JMP_C    = 2'b11
  } jmp_e;

  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] stack_q [SAVE_DEPTH];

  logic [FLAG_W-1:0] test_mask;
  logic [FLAG_W-1:0] nxt;
  logic [FLAG_W-1:0] top;
  logic              push;

  // One-hot selector of the flag the current jump tests.
  always_comb begin
    test_mask = '0;
    unique case (jmp_e'(jmp_cond))
      JMP_Z:   test_mask[ZERO_B]  = 1'b1;
      JMP_N:   test_mask[NEG_B]   = 1'b1;
      JMP_C:   test_mask[CARRY_B] = 1'b1;
      default: test_mask = '0;
    endcase
  end

  // No alu_flags bypass: the decision only sees registered flags.
  assign branch_taken = (|(ccr_q & test_mask)) && !flush;

  // A taken jump clears its tested flag, overriding any write to that bit.
  assign nxt = ((flag_we & alu_flags) | (~flag_we & ccr_q))
             & ~(branch_taken ? test_mask : '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) top = stack_q[i];
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    ccr_d = ccr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (!stall && !flush) begin
      if (rti_restore) begin
        if (cnt_q != '0) begin
          ccr_d = top;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ccr_d = nxt;
          err_d = 1'b1;
        end
        if (int_save) err_d = 1'b1;
      end else if (int_save) begin
        ccr_d = nxt;
        if (cnt_q < CNT_W'(SAVE_DEPTH)) begin
          push  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else begin
        ccr_d = nxt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ccr_q <= ccr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // NOTE: the save stack is tiny and must read back as zero after reset, so it is reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SAVE_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        if (push && cnt_q == CNT_W'(i)) stack_q[i] <= nxt;
      end
    end
  end

  assign ccr        = ccr_q;
  assign save_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: a vector table plus hand-written reset and
// stack corner sequences, with post-edge expectations queued in a scoreboard.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_flags, flag_we;
  logic       stall, flush, int_save, rti_restore;
  logic [1:0] jmp_cond;
  logic [2:0] ccr;
  logic       branch_taken, err;
  logic [1:0] save_count;

  ccr_unit #(.FLAG_W(3), .SAVE_DEPTH(2), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_flags    (alu_flags),
    .flag_we      (flag_we),
    .stall        (stall),
    .flush        (flush),
    .jmp_cond     (jmp_cond),
    .int_save     (int_save),
    .rti_restore  (rti_restore),
    .ccr          (ccr),
    .branch_taken (branch_taken),
    .save_count   (save_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] we, alu;
    logic       stl, fls, isv, rti;
    logic [1:0] jc;
    logic       exp_bt;
    logic [2:0] exp_ccr;
    logic [1:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] ccr;
    logic [1:0] cnt;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t v(input string name, input logic [2:0] we, input logic [2:0] alu,
                             input logic stl, input logic fls, input logic [1:0] jc,
                             input logic isv, input logic rti, input logic exp_bt,
                             input logic [2:0] exp_ccr, input logic [1:0] exp_cnt,
                             input logic exp_err);
    vec_t r;
    r.name = name; r.we = we; r.alu = alu; r.stl = stl; r.fls = fls; r.jc = jc;
    r.isv = isv; r.rti = rti; r.exp_bt = exp_bt; r.exp_ccr = exp_ccr;
    r.exp_cnt = exp_cnt; r.exp_err = exp_err;
    return r;
  endfunction

  task automatic idle_inputs();
    alu_flags = '0; flag_we = '0; stall = 0; flush = 0;
    jmp_cond = 2'b00; int_save = 0; rti_restore = 0;
  endtask

  // Drive one vector, check the same-cycle jump decision, queue the post-edge
  // state and compare it once the edge has passed.
  task automatic apply(input vec_t t);
    exp_t e, got;
    flag_we = t.we; alu_flags = t.alu; stall = t.stl; flush = t.fls;
    jmp_cond = t.jc; int_save = t.isv; rti_restore = t.rti;
    #1;
    check({t.name, ".bt"}, 32'(branch_taken), 32'(t.exp_bt));
    e.name = t.name; e.ccr = t.exp_ccr; e.cnt = t.exp_cnt; e.err = t.exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({t.name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check({got.name, ".ccr"}, 32'(ccr), 32'(got.ccr));
      check({got.name, ".cnt"}, 32'(save_count), 32'(got.cnt));
      check({got.name, ".err"}, 32'(err), 32'(got.err));
    end
    idle_inputs();
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".ccr"}, 32'(ccr), 32'd0);
    check({name, ".cnt"}, 32'(save_count), 32'd0);
    check({name, ".err"}, 32'(err), 32'd0);
    check({name, ".bt"}, 32'(branch_taken), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               name        we      alu     stl fls jc     isv rti bt  ccr     cnt    err
    vecs.push_back(v("wr101",    3'b111, 3'b101, 0,  0,  2'b00, 0,  0,  0,  3'b101, 2'd0, 0));
    vecs.push_back(v("jz_take",  3'b000, 3'b000, 0,  0,  2'b01, 0,  0,  1,  3'b100, 2'd0, 0));
    vecs.push_back(v("jc_not",   3'b000, 3'b000, 0,  0,  2'b11, 0,  0,  0,  3'b100, 2'd0, 0));
    vecs.push_back(v("jn_take",  3'b000, 3'b000, 0,  0,  2'b10, 0,  0,  1,  3'b000, 2'd0, 0));
    vecs.push_back(v("stall_wr", 3'b010, 3'b111, 1,  0,  2'b00, 0,  0,  0,  3'b000, 2'd0, 0));
    vecs.push_back(v("flush_wr", 3'b010, 3'b111, 0,  1,  2'b00, 0,  0,  0,  3'b000, 2'd0, 0));
    vecs.push_back(v("wr010",    3'b010, 3'b111, 0,  0,  2'b00, 0,  0,  0,  3'b010, 2'd0, 0));
    vecs.push_back(v("jc_stall", 3'b000, 3'b000, 1,  0,  2'b11, 0,  0,  1,  3'b010, 2'd0, 0));
    vecs.push_back(v("jc_flush", 3'b000, 3'b000, 0,  1,  2'b11, 0,  0,  0,  3'b010, 2'd0, 0));
    vecs.push_back(v("clr_ovr",  3'b010, 3'b010, 0,  0,  2'b11, 0,  0,  1,  3'b000, 2'd0, 0));
    vecs.push_back(v("wr011",    3'b011, 3'b011, 0,  0,  2'b00, 0,  0,  0,  3'b011, 2'd0, 0));
    vecs.push_back(v("push1",    3'b000, 3'b000, 0,  0,  2'b00, 1,  0,  0,  3'b011, 2'd1, 0));
    vecs.push_back(v("push2",    3'b111, 3'b100, 0,  0,  2'b00, 1,  0,  0,  3'b100, 2'd2, 0));
    vecs.push_back(v("rti_stl",  3'b111, 3'b001, 1,  0,  2'b00, 0,  1,  0,  3'b100, 2'd2, 0));
    vecs.push_back(v("rti_fls",  3'b111, 3'b001, 0,  1,  2'b00, 0,  1,  0,  3'b100, 2'd2, 0));
    vecs.push_back(v("overflow", 3'b000, 3'b000, 0,  0,  2'b00, 1,  0,  0,  3'b100, 2'd2, 1));
    vecs.push_back(v("pop2",     3'b111, 3'b001, 0,  0,  2'b00, 0,  1,  0,  3'b100, 2'd1, 1));
    vecs.push_back(v("pop1",     3'b000, 3'b000, 0,  0,  2'b00, 0,  1,  0,  3'b011, 2'd0, 1));
    vecs.push_back(v("underfl",  3'b000, 3'b000, 0,  0,  2'b00, 0,  1,  0,  3'b011, 2'd0, 1));
    vecs.push_back(v("undf_wr",  3'b111, 3'b110, 0,  0,  2'b00, 0,  1,  0,  3'b110, 2'd0, 1));
    vecs.push_back(v("err_stky", 3'b000, 3'b000, 0,  0,  2'b00, 0,  0,  0,  3'b110, 2'd0, 1));

    idle_inputs();
    rst = 1'b1;
    #12;
    check_reset_state("reset");
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Simultaneous save and restore: the pop wins, the save is dropped, err sets.
    rst = 1'b1; #1; rst = 1'b0;
    check_reset_state("reset2");
    apply(v("sv110",     3'b111, 3'b110, 0, 0, 2'b00, 1, 0, 0, 3'b110, 2'd1, 0));
    apply(v("both",      3'b111, 3'b001, 0, 0, 2'b00, 1, 1, 0, 3'b110, 2'd0, 1));

    // Asynchronous reset in mid-cycle with a full stack and err set.
    rst = 1'b1; #1; rst = 1'b0;
    apply(v("sv111a",    3'b111, 3'b111, 0, 0, 2'b00, 1, 0, 0, 3'b111, 2'd1, 0));
    apply(v("sv111b",    3'b000, 3'b000, 0, 0, 2'b00, 1, 0, 0, 3'b111, 2'd2, 0));
    apply(v("ovf_again", 3'b000, 3'b000, 0, 0, 2'b00, 1, 0, 0, 3'b111, 2'd2, 1));
    jmp_cond = 2'b01;
    #1;
    check("pre_rst.bt", 32'(branch_taken), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    #1;
    rst = 1'b0;
    jmp_cond = 2'b00;
    @(posedge clk);
    #1;
    check_reset_state("post_rst");

    if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register stage directly downstream of the execute-stage ALU in the 16-bit pipelined processor.
- Each cycle it registers the ALU's {Negative, Carry, Zero} flag vector under a per-bit write mask.
- It evaluates conditional jumps (JZ/JN/JC) against the registered flags, and clears the tested flag when the jump is taken.
- It keeps a small LIFO of saved flag sets for interrupt entry and RTI return.
- Its ccr output feeds back to the ALU flag inputs and to the branch/fetch logic.

Parameters:
- FLAG_W, 3, flag vector width; bit 2 = Negative, bit 1 = Carry, bit 0 = Zero.
- SAVE_DEPTH, 2, number of entries in the interrupt save stack (nesting depth).
- CNT_W, 2, width of save_count; must be at least clog2(SAVE_DEPTH+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_flags  input  FLAG_W  flag vector produced by the ALU for the instruction currently in EX.
- flag_we  input  FLAG_W  per-bit write mask from decode; 1 = that flag takes alu_flags.
- stall  input  1  hold: no state changes this cycle.
- flush  input  1  EX instruction is a bubble: ignore flag_we, jmp_cond, int_save and rti_restore.
- jmp_cond  input  2  jump type: 00 none, 01 JZ, 10 JN, 11 JC.
- int_save  input  1  interrupt accepted: push flags onto the save stack.
- rti_restore  input  1  RTI in EX: pop the save stack into ccr.
- ccr  output  FLAG_W  registered flags.
- branch_taken  output  1  combinational jump decision.
- save_count  output  CNT_W  number of valid stack entries.
- err  output  1  sticky error: stack overflow, stack underflow, or int_save and rti_restore in the same cycle.

Behaviour:
- Reset (asynchronous): ccr=000, all stack entries=000, save_count=0, err=0.
  - branch_taken is combinational and is 0 whenever reset holds ccr at 000.
- branch_taken (combinational, no latency):
  - jmp_cond=01: branch_taken=ccr[0]. jmp_cond=10: ccr[2]. jmp_cond=11: ccr[1]. jmp_cond=00: 0.
  - Forced to 0 when flush=1.
  - Not gated by stall; the consumer qualifies it.
- Next-state flags (nxt), computed per bit:
  - nxt[i] = flag_we[i] ? alu_flags[i] : ccr[i].
  - If branch_taken=1, the tested bit is then forced to 0 in nxt (the clear overrides any write to that bit).
- Per-cycle priority, highest first:
  1. rst.
  2. stall=1: everything holds, including err.
  3. flush=1: everything holds.
  4. rti_restore=1:
     - save_count>0: ccr <= top entry, save_count decrements; nxt is discarded.
     - save_count==0: ccr <= nxt, err <= 1.
     - If int_save is also 1: the save is dropped and err <= 1.
  5. int_save=1:
     - save_count<SAVE_DEPTH: push nxt, save_count increments, ccr <= nxt.
     - save_count==SAVE_DEPTH (full): no push, ccr <= nxt, err <= 1.
  6. Otherwise: ccr <= nxt.
- Stack:
  - LIFO; the top is index save_count-1.
  - Push writes index save_count; pop reads index save_count-1.
  - Popped entries are not cleared.
- Latency:
  - A flag written in cycle N is visible on ccr, and to branch_taken, from cycle N+1.
  - There is no bypass of alu_flags into branch_taken; a hazard unit must separate a flag-writing instruction from a dependent jump.
- err clears only on rst.
- Reset asserted mid-sequence (e.g. with save_count=2) returns all state to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then hold flag_we=111, alu_flags=101 for one cycle → ccr=101 next cycle; branch_taken=0 while jmp_cond=00.
- ccr=101, jmp_cond=01 (JZ) → branch_taken=1 in the same cycle; next cycle ccr=100. Repeat with jmp_cond=11 (JC) on ccr=100 → branch_taken=0, ccr stays 100.
- flag_we=010, alu_flags=111 from ccr=000 → ccr=010. Same stimulus with stall=1 → ccr stays 000. Same stimulus with flush=1 → ccr stays 000.
- Nesting and overflow:
  - ccr=011, int_save → save_count=1.
  - Write flags 100, int_save → save_count=2.
  - Third int_save → err=1, save_count stays 2.
  - rti_restore → ccr=100. rti_restore → ccr=011, save_count=0.
  - Further rti_restore → err remains 1, ccr unchanged (flag_we=000).
- int_save and rti_restore both asserted with save_count=1 holding 110 → ccr=110, save_count=0, err=1.
- Assert rst asynchronously mid-cycle with save_count=2, ccr=111 → ccr=000, save_count=0, err=0 immediately, before the next clock edge.
